// File: rtl/ex_pkg.sv
// Shared opcodes, FSM state type and helpers for the execute stage.
package ex_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR  = 6'b000011;
  localparam logic [5:0] OP_XOR = 6'b000100;
  localparam logic [5:0] OP_SLT = 6'b000101;
  localparam logic [5:0] OP_MUL = 6'b000110;
  localparam logic [5:0] OP_LW  = 6'b010000;
  localparam logic [5:0] OP_SW  = 6'b010001;
  localparam logic [5:0] OP_BEQ = 6'b100000;
  localparam logic [5:0] OP_JMP = 6'b100001;

  typedef enum logic [1:0] {IDLE, MUL, DONE} ex_state_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle after start.
module ex_mul_iter #(
  parameter int XLEN       = ex_pkg::XLEN,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(MUL_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

  logic [XLEN-1:0] mcand_p0;
  logic [XLEN-1:0] mplier_p0;
  logic [XLEN-1:0] acc_p0;
  logic [CW-1:0]   cnt_p0;

  // done marks the cycle whose step is the final one, so the caller can
  // leave its wait state on the same edge that completes the product.
  assign done    = busy & (cnt_p0 == LAST);
  assign product = acc_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      cnt_p0    <= '0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      acc_p0    <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt_p0    <= '0;
      mcand_p0  <= a;
      mplier_p0 <= b;
      acc_p0    <= '0;
    end else if (busy) begin
      if (mplier_p0[0]) acc_p0 <= acc_p0 + mcand_p0;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      cnt_p0    <= cnt_p0 + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU/branch unit feeding a one-entry output register.
// Define EX_MUL_EN to add the iterative multiplier for OP_MUL; otherwise MUL is illegal.
module execute_stage #(
  parameter int XLEN       = ex_pkg::XLEN,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [31:0]     Imm,
  input  logic [31:0]     npc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_op,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] store_data,
  output logic            redirect,
  output logic [31:0]     target,
  output logic            illegal
);
  import ex_pkg::*;

  logic            slot_free;
  logic            accept;
  logic            load_alu;
  logic [XLEN-1:0] imm_x;
  logic [XLEN-1:0] alu_res;
  logic            alu_ill;
  logic            alu_taken;
  logic [31:0]     alu_tgt;

  assign slot_free = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign imm_x     = {{(XLEN-16){Imm[15]}}, Imm[15:0]};

  always_comb begin
    alu_res   = '0;
    alu_ill   = 1'b0;
    alu_taken = 1'b0;
    alu_tgt   = '0;
    case (op)
      OP_ADD: alu_res = A + B;
      OP_SUB: alu_res = A - B;
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_LW, OP_SW: alu_res = A + imm_x;
      OP_BEQ: begin
        alu_taken = (A == '0);
        alu_tgt   = npc + (sext16(Imm[15:0]) << 2);
      end
      OP_JMP: begin
        alu_taken = 1'b1;
        alu_tgt   = {npc[31:28], Imm[25:0], 2'b00};
      end
`ifdef EX_MUL_EN
      OP_MUL: ;
`endif
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef EX_MUL_EN
  ex_state_t       state;
  logic            is_mul;
  logic            load_mul;
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  logic [XLEN-1:0] b_p0;

  assign is_mul   = (op == OP_MUL);
  assign in_ready = (state == IDLE) & slot_free;
  assign load_alu = accept & ~is_mul;
  assign load_mul = (state == DONE) & slot_free;

  ex_mul_iter #(.XLEN(XLEN), .MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept & is_mul),
    .a       (A),
    .b       (B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      b_p0  <= '0;
    end else begin
      case (state)
        IDLE: if (accept && is_mul) begin
          state <= MUL;
          b_p0  <= B;
        end
        MUL:  if (mul_done || !mul_busy) state <= DONE;
        DONE: if (slot_free) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign in_ready = slot_free;
  assign load_alu = accept;
`endif

  // Output register: loads on a new entry, holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_op     <= '0;
      result     <= '0;
      store_data <= '0;
      redirect   <= 1'b0;
      target     <= '0;
      illegal    <= 1'b0;
    end else begin
      // Only a freshly loaded entry can pulse redirect, so holding never re-fires it.
      redirect <= load_alu & alu_taken;
      if (load_alu) begin
        out_valid  <= 1'b1;
        out_op     <= op;
        result     <= alu_res;
        store_data <= B;
        target     <= alu_tgt;
        illegal    <= alu_ill;
`ifdef EX_MUL_EN
      end else if (load_mul) begin
        out_valid  <= 1'b1;
        out_op     <= OP_MUL;
        result     <= mul_product;
        store_data <= b_p0;
        target     <= '0;
        illegal    <= 1'b0;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage with a transaction-level reference model.
module tb_execute_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  op = '0;
  logic [31:0] A = '0, B = '0, Imm = '0, npc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  out_op;
  logic [31:0] result, store_data, target;
  logic        redirect, illegal;

  execute_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .Imm(Imm), .npc(npc),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .result(result), .store_data(store_data), .redirect(redirect),
    .target(target), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] res;
    logic [31:0] sd;
    logic [31:0] tgt;
    logic        ill;
    logic        taken;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic held = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [31:0] pc);
    exp_t e;
    int   off;
    off = $signed(imm[15:0]);
    e.op = o; e.res = 0; e.sd = b; e.tgt = 0; e.ill = 0; e.taken = 0;
    case (o)
      OP_ADD: e.res = a + b;
      OP_SUB: e.res = a - b;
      OP_AND: e.res = a & b;
      OP_OR:  e.res = a | b;
      OP_XOR: e.res = a ^ b;
      OP_SLT: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef EX_MUL_EN
      OP_MUL: e.res = a * b;
`endif
      OP_LW, OP_SW: e.res = a + off;
      OP_BEQ: begin e.taken = (a == 0); e.tgt = pc + off * 4; end
      OP_JMP: begin e.taken = 1; e.tgt = {pc[31:28], imm[25:0], 2'b00}; end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic monitor();
    if (out_valid && !held) begin
      if (q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
      else begin
        cur = q.pop_front();
        check("result", result, cur.res);
        check("out_op", {26'd0, out_op}, {26'd0, cur.op});
        check("illegal", {31'd0, illegal}, {31'd0, cur.ill});
        check("store_data", store_data, cur.sd);
        check("redirect", {31'd0, redirect}, {31'd0, cur.taken});
        if (cur.taken) check("target", target, cur.tgt);
      end
    end else if (out_valid) begin
      check("hold_result", result, cur.res);
      check("hold_op", {26'd0, out_op}, {26'd0, cur.op});
      check("hold_redirect", {31'd0, redirect}, 32'd0);
    end else begin
      check("idle_redirect", {31'd0, redirect}, 32'd0);
    end
  endtask

  task automatic step(input logic v, input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [31:0] pc, input logic ordy);
    @(negedge clk);
    monitor();
    in_valid = v; op = o; A = a; B = b; Imm = imm; npc = pc; out_ready = ordy;
    #1;
    if (v && in_ready) q.push_back(model(o, a, b, imm, pc));
    held = out_valid && !out_ready;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'd0, 0, 0, 0, 0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_redirect", {31'd0, redirect}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_store_data", store_data, 32'd0);
    check("rst_target", target, 32'd0);
    check("rst_out_op", {26'd0, out_op}, 32'd0);
    q.delete();
    held = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [11];
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_MUL, OP_LW, OP_SW, OP_BEQ, OP_JMP};

    do_reset();

    step(1, OP_ADD, 7, 5, 0, 0, 1); idle(1);
    check("add", result, 32'd12);
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_redirect", {31'd0, redirect}, 32'd0);
    step(1, OP_SUB, 3, 5, 0, 0, 1); idle(1);
    check("sub", result, 32'hFFFFFFFE);
    step(1, OP_SLT, 32'hFFFFFFFF, 1, 0, 0, 1); idle(1);
    check("slt", result, 32'd1);
    step(1, OP_LW, 32'h100, 0, 32'h0000FFFC, 0, 1); idle(1);
    check("lw", result, 32'hFC);

    step(1, OP_BEQ, 0, 0, 32'h3, 32'h40, 1); idle(1);
    check("beq_redirect", {31'd0, redirect}, 32'd1);
    check("beq_target", target, 32'h4C);
    idle(1);
    check("beq_pulse_end", {31'd0, redirect}, 32'd0);
    step(1, OP_BEQ, 1, 0, 32'h3, 32'h40, 1); idle(1);
    check("beq_not_taken", {31'd0, redirect}, 32'd0);
    step(1, OP_JMP, 0, 0, 32'h10, 32'h80000010, 1); idle(1);
    check("jmp_redirect", {31'd0, redirect}, 32'd1);
    check("jmp_target", target, 32'h80000040);
    idle(1);

`ifdef EX_MUL_EN
    begin
      int lo = 0;
      int k  = 0;
      step(1, OP_MUL, 123, 456, 0, 0, 1);
      while (k < 200) begin
        idle(1);
        k++;
        if (out_valid) break;
        if (!in_ready) lo++;
      end
      check("mul_done", {31'd0, out_valid}, 32'd1);
      check("mul_busy_cycles", lo, 33);
      check("mul_result", result, 32'd56088);
      idle(1);
    end
`else
    step(1, OP_MUL, 123, 456, 0, 0, 1); idle(1);
    check("mul_illegal", {31'd0, illegal}, 32'd1);
    check("mul_result_zero", result, 32'd0);
    idle(1);
`endif

    step(1, OP_ADD, 1, 2, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, OP_ADD, 9, 9, 0, 0, 0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", result, 32'd3);
    end
    idle(2);

    step(1, OP_XOR, 5, 3, 0, 0, 0);
    idle(0);
    step(0, 6'd0, 0, 0, 0, 0, 0);
    do_reset();
    idle(3);

`ifdef EX_MUL_EN
    step(1, OP_MUL, 32'hDEAD, 32'hBEEF, 0, 0, 1);
    idle(10);
    do_reset();
    idle(40);
`endif

    for (int n = 0; n < 400; n++) begin
      logic [5:0]  o;
      logic [31:0] a;
      int          idx;
      idx = $urandom_range(0, 11);
      o   = (idx == 11) ? 6'($urandom) : ops[idx];
      a   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step($urandom_range(0, 9) < 7, o, a, $urandom, $urandom, $urandom, $urandom_range(0, 3) != 0);
    end

    for (int n = 0; n < 200; n++) begin
      if (q.size() == 0 && !out_valid) break;
      idle(1);
    end
    check("drain_empty", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (EX) stage, directly downstream of the decode stage.
- Consumes decoded op, operand A, operand B, immediate Imm and the next-PC. Produces an ALU/address result, store data, and a branch/jump redirect.
- Single-cycle ALU for most ops; iterative 32-cycle shift-add multiplier for MUL.
- Valid/ready handshakes on both sides, with a one-entry output register, so downstream MEM backpressure stalls EX cleanly.

Parameters:
- XLEN, 32, datapath width (A, B, result).
- MUL_CYCLES, 32, iterations of the multiplier (must equal XLEN).

Ports:
- clk  in  1  stage clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents a valid op/A/B/Imm/npc.
- in_ready  out  1  EX accepts the input this cycle.
- op  in  6  opcode from decode.
- A  in  XLEN  operand A; for BEQ this is Ri^Rj, for JMP it is 0.
- B  in  XLEN  operand B (Rk for ALU ops, store data for SW).
- Imm  in  32  immediate: bits[15:0] for I-type, bits[25:0] for JMP.
- npc  in  32  PC+4 of this instruction.
- out_valid  out  1  result register holds a valid entry.
- out_ready  in  1  MEM stage consumes the entry.
- out_op  out  6  registered op.
- result  out  XLEN  ALU result or effective address.
- store_data  out  XLEN  registered B (SW only meaningful).
- redirect  out  1  one-cycle pulse: branch taken or jump.
- target  out  32  redirect target, valid while redirect=1.
- illegal  out  1  registered: op unrecognised (entry still flows, no writeback implied).

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, redirect=0, illegal=0; result, store_data, target, out_op = 0.
  - FSM=IDLE; in_ready=1 after release.
- Accept rule: acceptance occurs on the rising edge where in_valid & in_ready.
  - in_ready = (FSM==IDLE) & (~out_valid | out_ready).
- Opcodes (single-cycle; result is registered on the accept edge, out_valid=1 next cycle):
  - 000000 ADD: A+B.
  - 000001 SUB: A-B.
  - 000010 AND.
  - 000011 OR.
  - 000100 XOR.
  - 000101 SLT: signed A<B ? 1 : 0.
  - 010000 LW / 010001 SW: result = A + sext(Imm[15:0]); store_data=B.
  - 100000 BEQ: taken iff A==0; target = npc + (sext(Imm[15:0])<<2); result=0.
  - 100001 JMP: target = {npc[31:28], Imm[25:0], 2'b00}; always taken; result=0.
  - Anything else: result=0, illegal=1.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- redirect asserts for exactly one cycle, coincident with the first cycle of out_valid for that entry. It does not re-pulse while the entry is held by out_ready=0.
- MUL (000110) state machine:
  - IDLE -> MUL on accept: load multiplicand=A, multiplier=B, acc=0, cnt=0; in_ready=0.
  - MUL: each cycle, if multiplier[0] then acc+=multiplicand; multiplicand<<=1; multiplier>>=1; cnt++. After MUL_CYCLES iterations -> DONE.
  - DONE: when output slot is free (~out_valid | out_ready), result = acc (low XLEN bits), out_valid=1, -> IDLE.
  - Latency from accept to out_valid: MUL_CYCLES+1 cycles, plus any backpressure.
- Output hold: while out_valid & ~out_ready, all outputs are frozen. If out_ready=1 and no new entry is produced, out_valid=0 next cycle.
- Simultaneous events: out_ready with a new accept in the same cycle -> back-to-back throughput of 1/cycle.
- Reset mid-MUL aborts immediately: FSM=IDLE, partial product discarded.

Optional Feature:
- EX_MUL_EN
  - Defined: MUL opcode is executed by the iterative multiplier as above.
  - Undefined: no multiplier hardware; MUL is treated as unrecognised (illegal=1, result=0, single-cycle); FSM reduces to IDLE only.

Decomposition:
- Package ex_pkg holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_MUL, OP_LW, OP_SW, OP_BEQ, OP_JMP.
  - FSM state typedef {IDLE, MUL, DONE}.
  - XLEN default.
- One sub-module: ex_mul_iter, the shift-add multiplier.
  - Ports: start, a, b, busy, done, product.
  - Instantiated only under EX_MUL_EN.

Test Plan:
- Reset, then ADD A=7 B=5 with out_ready=1 -> next cycle out_valid=1, result=12, redirect=0; SUB A=3 B=5 -> result=0xFFFFFFFE.
- SLT A=0xFFFFFFFF B=1 -> result=1; LW A=0x100 Imm=0xFFFC -> result=0xFC.
- BEQ A=0 npc=0x40 Imm=0x0003 -> redirect pulse 1 cycle, target=0x4C; BEQ A=1 -> redirect=0.
- JMP npc=0x80000010 Imm=0x10 -> target=0x80000040.
- MUL A=123 B=456 (EX_MUL_EN) -> in_ready=0 for 33 cycles, result=56088; undefined macro -> illegal=1 next cycle.
- out_ready=0 for 5 cycles after an ADD -> outputs frozen, in_ready=0; assert rst_n=0 mid-MUL -> out_valid=0 and in_ready=1 after release.
